// File: rtl/mips_mc_core.sv
// Multicycle MIPS-subset core: fetch/decode/execute FSM over a single request/ready memory port.
// Latency: 3 cycles (branch/jump), 4 (ALU/sw), 5 (lw) with zero-wait memory; +1 per wait cycle.
// Backpressure: mem_rd/mem_wr held until mem_ready; MAX_WAIT unanswered cycles halt the core.
module mips_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        PCinit,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] pc_dbg,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WB   = 4'd6,
    MEM_WR   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    HALT     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state, state_nx;
  logic [31:0] pc, ir, mdr, a, b, alu_out;
  logic [7:0]  wait_cnt;
  logic [31:0] rf [0:31];

  logic        timeout, illegal;
  logic [31:0] alu_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Instruction fields; target covers IR[25:0], imm covers rd/shamt/funct.
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] simm, rs_val, rt_val;
  logic        branch_taken;

  assign op     = ir[31:26];
  assign target = ir[25:0];
  assign rs     = target[25:21];
  assign rt     = target[20:16];
  assign imm    = target[15:0];
  assign rd     = imm[15:11];
  assign funct  = imm[5:0];
  assign simm   = {{16{imm[15]}}, imm};

  // $0 is hardwired to zero on the read side; rf[0] is never written.
  assign rs_val = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : rf[rt];

  assign branch_taken = (op == OP_BEQ) ? (a == b) : (a != b);

  assign mem_wdata = b;
  assign halted    = (state == HALT);
  assign pc_dbg    = pc;
  assign state_dbg = state;

  // ALU: R-type ops in EXEC_R, addi/slti in EXEC_I, address add elsewhere.
  always_comb begin
    alu_res = a + simm;
    if (state == EXEC_R) begin
      case (funct)
        F_SUB:   alu_res = a - b;
        F_AND:   alu_res = a & b;
        F_OR:    alu_res = a | b;
        F_SLT:   alu_res = {31'd0, $signed(a) < $signed(b)};
        default: alu_res = a + b;
      endcase
    end else if (state == EXEC_I && op == OP_SLTI) begin
      alu_res = {31'd0, $signed(a) < $signed(simm)};
    end
  end

  // Next-state logic and memory port control.
  always_comb begin
    state_nx = state;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = pc;
    timeout  = 1'b0;
    illegal  = 1'b0;
    case (state)
      FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) state_nx = DECODE;
        else if (wait_cnt == WAIT_LAST) begin
          state_nx = HALT;
          timeout  = 1'b1;
        end
      end
      DECODE: begin
        case (op)
          OP_RTYPE: begin
            case (funct)
              F_ADD, F_SUB, F_AND, F_OR, F_SLT: state_nx = EXEC_R;
              F_JR:    state_nx = JUMP;
              default: illegal  = 1'b1;
            endcase
          end
          OP_ADDI, OP_SLTI: state_nx = EXEC_I;
          OP_LW, OP_SW:     state_nx = MEM_ADDR;
          OP_BEQ, OP_BNE:   state_nx = BRANCH;
          OP_J, OP_JAL:     state_nx = JUMP;
          default:          illegal  = 1'b1;
        endcase
        if (illegal) state_nx = HALT;
      end
      EXEC_R, EXEC_I: state_nx = ALU_WB;
      MEM_ADDR:       state_nx = (op == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD: begin
        mem_rd   = 1'b1;
        mem_addr = alu_out;
        if (mem_ready) state_nx = MEM_WB;
        else if (wait_cnt == WAIT_LAST) begin
          state_nx = HALT;
          timeout  = 1'b1;
        end
      end
      MEM_WR: begin
        mem_wr   = 1'b1;
        mem_addr = alu_out;
        if (mem_ready) state_nx = FETCH;
        else if (wait_cnt == WAIT_LAST) begin
          state_nx = HALT;
          timeout  = 1'b1;
        end
      end
      MEM_WB, ALU_WB, BRANCH, JUMP: state_nx = FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = HALT;
    endcase
  end

  // Register-file write port: ALU_WB, MEM_WB and jal only.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = alu_out;
    case (state)
      ALU_WB: begin
        rf_we    = 1'b1;
        rf_waddr = (op == OP_RTYPE) ? rd : rt;
      end
      MEM_WB: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = mdr;
      end
      JUMP: begin
        rf_we    = (op == OP_JAL);
        rf_waddr = 5'd31;
        rf_wdata = pc;
      end
      default: ;
    endcase
  end

  // State register, per-state wait counter and sticky halt cause.
  always_ff @(posedge clk) begin
    if (PCinit) begin
      state      <= FETCH;
      wait_cnt   <= 8'd0;
      halt_cause <= 2'd0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        wait_cnt <= 8'd0;
      else if ((mem_rd || mem_wr) && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
      if (timeout)
        halt_cause <= 2'd2;
      else if (illegal)
        halt_cause <= 2'd1;
    end
  end

  // Datapath registers; updates are tied to the state being left.
  always_ff @(posedge clk) begin
    if (PCinit) begin
      pc      <= RESET_PC;
      ir      <= 32'd0;
      mdr     <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      alu_out <= 32'd0;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
        end
        DECODE: begin
          a       <= rs_val;
          b       <= rt_val;
          alu_out <= pc + {simm[29:0], 2'b00};
        end
        EXEC_R, EXEC_I, MEM_ADDR: alu_out <= alu_res;
        MEM_RD: if (mem_ready) mdr <= mem_rdata;
        BRANCH: if (branch_taken) pc <= alu_out;
        JUMP:   pc <= (op == OP_RTYPE) ? a : {pc[31:28], target, 2'b00};
        default: ;
      endcase
    end
  end

  // Register file storage; not cleared by reset, writes to $0 dropped.
  always_ff @(posedge clk) begin
    if (rf_we && !PCinit && rf_waddr != 5'd0)
      rf[rf_waddr] <= rf_wdata;
  end

endmodule

// File: tb/tb_mips_mc_core.sv
`timescale 1ns/1ps
module tb_mips_mc_core;

  logic        clk = 1'b0;
  logic        PCinit;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] pc_dbg;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];

  mips_mc_core dut (
    .clk        (clk),
    .PCinit     (PCinit),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .halted     (halted),
    .halt_cause (halt_cause),
    .pc_dbg     (pc_dbg),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Word memory, combinational read, write on accepted store.
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_wr && mem_ready) mem[mem_addr[11:2]] <= mem_wdata;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    mem[a[11:2]] = d;
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  task automatic do_reset;
    PCinit = 1'b1; mem_ready = 1'b1;
    step(2);
    PCinit = 1'b0;
  endtask

  task automatic test_reset;
    clear_mem();
    PCinit = 1'b1; mem_ready = 1'b1;
    step(2);
    checks++; if (state_dbg !== 4'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state_dbg); end
    checks++; if (pc_dbg !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", pc_dbg); end
    checks++; if (halted !== 1'b0 || halt_cause !== 2'd0) begin errors++; $display("FAIL rst_halt got %b/%0d want 0/0", halted, halt_cause); end
    checks++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rst_bus got rd=%b wr=%b addr=%h want 1 0 0", mem_rd, mem_wr, mem_addr); end
    PCinit = 1'b0;
  endtask

  task automatic test_program;
    clear_mem();
    wr_word(32'h0, 32'h20010005);  // addi $1,$0,5
    wr_word(32'h4, 32'h2002FFFD);  // addi $2,$0,-3
    wr_word(32'h8, 32'h00221820);  // add $3,$1,$2
    wr_word(32'hC, 32'hAC030040);  // sw $3,0x40($0)
    do_reset();
    step(15);
    checks++; if (state_dbg !== 4'd7) begin errors++; $display("FAIL prog_memwr_state got %0d want 7", state_dbg); end
    checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL prog_wr_strobe got wr=%b rd=%b want 1 0", mem_wr, mem_rd); end
    checks++; if (mem_addr !== 32'h40 || mem_wdata !== 32'h2) begin errors++; $display("FAIL prog_wr_bus got %h/%h want 40/2", mem_addr, mem_wdata); end
    step(1);
    checks++; if (state_dbg !== 4'd0 || pc_dbg !== 32'h10) begin errors++; $display("FAIL prog_end got st=%0d pc=%h want 0 10", state_dbg, pc_dbg); end
    checks++; if (rd_word(32'h40) !== 32'h2) begin errors++; $display("FAIL prog_mem40 got %h want 2", rd_word(32'h40)); end
  endtask

  task automatic test_lw_wait;
    clear_mem();
    wr_word(32'h0, 32'h8C040040);  // lw $4,0x40($0)
    wr_word(32'h4, 32'hAC040044);  // sw $4,0x44($0)
    wr_word(32'h40, 32'h2);
    do_reset();
    step(3);
    checks++; if (state_dbg !== 4'd5 || mem_addr !== 32'h40) begin errors++; $display("FAIL lw_memrd got st=%0d addr=%h want 5 40", state_dbg, mem_addr); end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_rd !== 1'b1 || state_dbg !== 4'd5) begin errors++; $display("FAIL lw_hold%0d got rd=%b st=%0d want 1 5", i, mem_rd, state_dbg); end
      step(1);
    end
    mem_ready = 1'b1;
    step(2);
    checks++; if (state_dbg !== 4'd0 || pc_dbg !== 32'h4) begin errors++; $display("FAIL lw_8cyc got st=%0d pc=%h want 0 4", state_dbg, pc_dbg); end
    step(4);
    checks++; if (rd_word(32'h44) !== 32'h2) begin errors++; $display("FAIL lw_value got %h want 2", rd_word(32'h44)); end
  endtask

  task automatic test_alu_ops;
    logic [31:0] prog [0:13];
    logic [31:0] want [0:5];
    prog = '{32'h20010005, 32'h2002FFFD, 32'h00223022, 32'h00223824, 32'h00224025,
             32'h0041482A, 32'h282AFFFF, 32'h284B0000, 32'hAC060080, 32'hAC070084,
             32'hAC080088, 32'hAC09008C, 32'hAC0A0090, 32'hAC0B0094};
    want = '{32'h8, 32'h5, 32'hFFFFFFFD, 32'h1, 32'h0, 32'h1};
    clear_mem();
    for (int i = 0; i < 14; i++) wr_word(32'(i * 4), prog[i]);
    for (int i = 0; i < 6; i++) wr_word(32'h80 + 32'(i * 4), 32'hDEADBEEF);
    do_reset();
    step(56);
    checks++; if (state_dbg !== 4'd0 || pc_dbg !== 32'h38) begin errors++; $display("FAIL alu_end got st=%0d pc=%h want 0 38", state_dbg, pc_dbg); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rd_word(32'h80 + 32'(i * 4)) !== want[i]) begin
        errors++; $display("FAIL alu_res%0d got %h want %h", i, rd_word(32'h80 + 32'(i * 4)), want[i]);
      end
    end
  endtask

  task automatic test_branch;
    clear_mem();
    wr_word(32'h0, 32'h1021FFFF);  // beq $1,$1,-1
    do_reset();
    step(1);
    checks++; if (pc_dbg !== 32'h4 || state_dbg !== 4'd1) begin errors++; $display("FAIL beq_fetch got pc=%h st=%0d want 4 1", pc_dbg, state_dbg); end
    step(2);
    checks++; if (pc_dbg !== 32'h0 || state_dbg !== 4'd0) begin errors++; $display("FAIL beq_loop1 got pc=%h st=%0d want 0 0", pc_dbg, state_dbg); end
    step(3);
    checks++; if (pc_dbg !== 32'h0 || state_dbg !== 4'd0) begin errors++; $display("FAIL beq_loop2 got pc=%h st=%0d want 0 0", pc_dbg, state_dbg); end
    clear_mem();
    wr_word(32'h0, 32'h1421FFFF);  // bne $1,$1,-1
    do_reset();
    step(3);
    checks++; if (pc_dbg !== 32'h4 || state_dbg !== 4'd0) begin errors++; $display("FAIL bne_fall got pc=%h st=%0d want 4 0", pc_dbg, state_dbg); end
  endtask

  task automatic test_jump;
    clear_mem();
    wr_word(32'h0, 32'h20000000);    // addi $0,$0,0
    wr_word(32'h4, 32'h20000000);
    wr_word(32'h8, 32'h0C000100);    // jal 0x100
    wr_word(32'h400, 32'h03E00008);  // jr $31
    wr_word(32'hC, 32'hAC1F0048);    // sw $31,0x48($0)
    do_reset();
    step(11);
    checks++; if (pc_dbg !== 32'h400 || state_dbg !== 4'd0) begin errors++; $display("FAIL jal_pc got pc=%h st=%0d want 400 0", pc_dbg, state_dbg); end
    step(3);
    checks++; if (pc_dbg !== 32'hC || state_dbg !== 4'd0) begin errors++; $display("FAIL jr_pc got pc=%h st=%0d want c 0", pc_dbg, state_dbg); end
    step(4);
    checks++; if (rd_word(32'h48) !== 32'hC) begin errors++; $display("FAIL jal_link got %h want c", rd_word(32'h48)); end
  endtask

  task automatic test_zero_reg;
    clear_mem();
    wr_word(32'h0, 32'h20050009);  // addi $5,$0,9
    wr_word(32'h4, 32'h20000007);  // addi $0,$0,7
    wr_word(32'h8, 32'h00002820);  // add $5,$0,$0
    wr_word(32'hC, 32'hAC05004C);  // sw $5,0x4C($0)
    wr_word(32'h4C, 32'hDEADBEEF);
    do_reset();
    step(16);
    checks++; if (rd_word(32'h4C) !== 32'h0) begin errors++; $display("FAIL zero_reg got %h want 0", rd_word(32'h4C)); end
  endtask

  task automatic test_illegal;
    clear_mem();
    wr_word(32'h0, 32'hFC000000);
    do_reset();
    step(1);
    checks++; if (state_dbg !== 4'd1 || halted !== 1'b0) begin errors++; $display("FAIL ill_decode got st=%0d h=%b want 1 0", state_dbg, halted); end
    step(1);
    checks++; if (halted !== 1'b1 || halt_cause !== 2'd1) begin errors++; $display("FAIL ill_halt got %b/%0d want 1/1", halted, halt_cause); end
    checks++; if (pc_dbg !== 32'h4 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL ill_pc got pc=%h rd=%b wr=%b want 4 0 0", pc_dbg, mem_rd, mem_wr); end
    step(4);
    checks++; if (state_dbg !== 4'd11 || halted !== 1'b1) begin errors++; $display("FAIL ill_absorb got st=%0d h=%b want 11 1", state_dbg, halted); end
    PCinit = 1'b1;
    step(1);
    PCinit = 1'b0;
    checks++; if (pc_dbg !== 32'h0 || halted !== 1'b0 || halt_cause !== 2'd0 || state_dbg !== 4'd0) begin
      errors++; $display("FAIL ill_recover got pc=%h h=%b c=%0d st=%0d want 0 0 0 0", pc_dbg, halted, halt_cause, state_dbg);
    end
  endtask

  task automatic test_timeout;
    clear_mem();
    do_reset();
    mem_ready = 1'b0;
    step(15);
    checks++; if (halted !== 1'b0 || state_dbg !== 4'd0 || mem_rd !== 1'b1) begin errors++; $display("FAIL to_early got h=%b st=%0d rd=%b want 0 0 1", halted, state_dbg, mem_rd); end
    step(1);
    checks++; if (halted !== 1'b1 || halt_cause !== 2'd2) begin errors++; $display("FAIL to_halt got %b/%0d want 1/2", halted, halt_cause); end
    checks++; if (pc_dbg !== 32'h0 || mem_rd !== 1'b0) begin errors++; $display("FAIL to_side got pc=%h rd=%b want 0 0", pc_dbg, mem_rd); end
  endtask

  task automatic test_reset_midop;
    clear_mem();
    wr_word(32'h0, 32'hAC010050);  // sw $1,0x50($0)
    wr_word(32'h50, 32'h12345678);
    do_reset();
    step(3);
    checks++; if (state_dbg !== 4'd7 || mem_wr !== 1'b1) begin errors++; $display("FAIL mid_wr got st=%0d wr=%b want 7 1", state_dbg, mem_wr); end
    mem_ready = 1'b0;
    step(2);
    PCinit = 1'b1;
    step(1);
    checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b1 || state_dbg !== 4'd0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL mid_abort got wr=%b rd=%b st=%0d addr=%h want 0 1 0 0", mem_wr, mem_rd, state_dbg, mem_addr);
    end
    PCinit = 1'b0;
    checks++; if (rd_word(32'h50) !== 32'h12345678) begin errors++; $display("FAIL mid_nowrite got %h want 12345678", rd_word(32'h50)); end
  endtask

  initial begin
    PCinit = 1'b1;
    mem_ready = 1'b1;
    test_reset();
    test_program();
    test_lw_wait();
    test_alu_ops();
    test_branch();
    test_jump();
    test_zero_reg();
    test_illegal();
    test_timeout();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
